obi_master_pipe: RTL and testbench

Parametrised OBI master adapter between a core load/store or fetch unit and an OBI bus. It supports up to MAX_OUTSTANDING pipelined transactions. Once a request is issued it is latched and held stable until granted, so the bus protocol stays compliant even if the core drops valid. Responses return in order, with per-transaction tagging of read/write, and protocol violations raise a sticky error flag.

---
 rtl/obi_pkg.sv | 24 ++
 rtl/obi_master_pipe_if.sv | 55 +++++
 rtl/obi_tag_fifo.sv | 59 +++++
 rtl/obi_master_pipe.sv | 134 +++++++++++++
 tb/tb_obi_master_pipe.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obi_pkg
// Brief    : Shared types, constants and address helper for the OBI master.
// Revision : 1.0
// ============================================================================
package obi_pkg;

  localparam int OBI_ATOP_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } obi_master_state_e;

  // Clears the byte-offset bits below the bus word; addresses up to 64 bits.
  function automatic logic [63:0] obi_align_addr(input logic [63:0] addr, input int lsb_w);
    logic [63:0] mask;
    mask = ~((64'd1 << lsb_w) - 64'd1);
    return addr & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_master_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : obi_master_pipe_if
// Brief    : Core-side, response and OBI bus signals of the OBI master adapter.
// Revision : 1.0
// ============================================================================
interface obi_master_pipe_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                          core_valid_i;
  logic                          core_ready_o;
  logic [ADDR_WIDTH-1:0]         core_addr_i;
  logic                          core_we_i;
  logic [BE_WIDTH-1:0]           core_be_i;
  logic [DATA_WIDTH-1:0]         core_wdata_i;
  logic                          resp_valid_o;
  logic [DATA_WIDTH-1:0]         resp_rdata_o;
  logic                          resp_err_o;
  logic                          resp_we_o;
  logic                          obi_req_o;
  logic                          obi_gnt_i;
  logic [ADDR_WIDTH-1:0]         obi_addr_o;
  logic                          obi_we_o;
  logic [BE_WIDTH-1:0]           obi_be_o;
  logic [DATA_WIDTH-1:0]         obi_wdata_o;
  logic [obi_pkg::OBI_ATOP_W-1:0] obi_atop_o;
  logic                          obi_rvalid_i;
  logic [DATA_WIDTH-1:0]         obi_rdata_i;
  logic                          obi_err_i;
  logic [CNT_WIDTH-1:0]          outstanding_o;
  logic                          proto_err_o;

  modport master (
    input  core_valid_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    output core_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_we_o,
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o,
    output outstanding_o, proto_err_o
  );

  modport slave (
    output core_valid_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  core_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_we_o,
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o,
    input  outstanding_o, proto_err_o
  );

endinterface
`default_nettype wire

// File: rtl/obi_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : obi_tag_fifo
// Brief    : DEPTH x WIDTH synchronous FIFO with simultaneous push/pop.
// Revision : 1.0
// ============================================================================
module obi_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push,
  input  logic [WIDTH-1:0]                 i_wdata,
  input  logic                             i_pop,
  output logic [WIDTH-1:0]                 o_rdata,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (i_pop && !i_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Read data is combinational so the caller can consume the head in the pop cycle.
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/obi_master_pipe.sv
`default_nettype none
// ============================================================================
// Module   : obi_master_pipe
// Brief    : Pipelined OBI master with grant-hold register and in-order tags.
// Revision : 1.0
// ============================================================================
module obi_master_pipe
  import obi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BE_WIDTH        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  obi_master_pipe_if.master     bus
);
  localparam int c_OFFSET_W = $clog2(BE_WIDTH);

  obi_master_state_e      r_state;
  obi_master_state_e      w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_hold_addr;
  logic                   r_hold_we;
  logic [BE_WIDTH-1:0]    r_hold_be;
  logic [DATA_WIDTH-1:0]  r_hold_wdata;
  logic                   r_proto_err;

  logic [ADDR_WIDTH-1:0]  w_core_addr_al;
  logic                   w_req;
  logic                   w_ready;
  logic                   w_latch;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_we;
  logic [BE_WIDTH-1:0]    w_be;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_tag;

  assign w_core_addr_al = ADDR_WIDTH'(obi_align_addr(64'(bus.core_addr_i), c_OFFSET_W));

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_ready     = 1'b0;
    w_latch     = 1'b0;
    w_addr      = '0;
    w_we        = 1'b0;
    w_be        = '0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        // Issue permission depends only on the registered count, never on rvalid.
        w_req = bus.core_valid_i & ~w_full;
        if (w_req) begin
          w_addr  = w_core_addr_al;
          w_we    = bus.core_we_i;
          w_be    = bus.core_be_i;
          w_wdata = bus.core_wdata_i;
        end
        w_ready = w_req & bus.obi_gnt_i;
        if (w_req && !bus.obi_gnt_i) begin
          w_latch     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_req   = 1'b1;
        w_addr  = r_hold_addr;
        w_we    = r_hold_we;
        w_be    = r_hold_be;
        w_wdata = r_hold_wdata;
        w_ready = bus.obi_gnt_i;
        if (bus.obi_gnt_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold_addr  <= '0;
      r_hold_we    <= 1'b0;
      r_hold_be    <= '0;
      r_hold_wdata <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_hold_addr  <= w_core_addr_al;
        r_hold_we    <= bus.core_we_i;
        r_hold_be    <= bus.core_be_i;
        r_hold_wdata <= bus.core_wdata_i;
      end
      if (bus.obi_rvalid_i && w_empty) r_proto_err <= 1'b1;
    end
  end

  // Responses with nothing outstanding are dropped and only flagged.
  assign w_pop = bus.obi_rvalid_i & ~w_empty;

  obi_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ready),
    .i_wdata (w_we),
    .i_pop   (w_pop),
    .o_rdata (w_tag),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (bus.outstanding_o)
  );

  assign bus.obi_req_o    = w_req;
  assign bus.obi_addr_o   = w_addr;
  assign bus.obi_we_o     = w_we;
  assign bus.obi_be_o     = w_be;
  assign bus.obi_wdata_o  = w_wdata;
  assign bus.obi_atop_o   = '0;
  assign bus.core_ready_o = w_ready;
  assign bus.resp_valid_o = w_pop;
  assign bus.resp_we_o    = w_pop & w_tag;
  assign bus.resp_err_o   = w_pop & bus.obi_err_i;
  assign bus.resp_rdata_o = (w_pop && !w_tag) ? bus.obi_rdata_i : '0;
  assign bus.proto_err_o  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_obi_master_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_master_pipe
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_obi_master_pipe;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_master_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

  obi_master_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_in();
    bus.core_valid_i = 1'b0; bus.core_addr_i = '0; bus.core_we_i = 1'b0;
    bus.core_be_i = '0; bus.core_wdata_i = '0; bus.obi_gnt_i = 1'b0;
    bus.obi_rvalid_i = 1'b0; bus.obi_rdata_i = '0; bus.obi_err_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic core_req(input logic [31:0] addr, input logic we, input logic [31:0] wd, input logic gnt);
    bus.core_valid_i = 1'b1; bus.core_addr_i = addr; bus.core_we_i = we;
    bus.core_be_i = 4'hF; bus.core_wdata_i = wd; bus.obi_gnt_i = gnt;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.obi_req_o, bus.core_ready_o, bus.resp_valid_o, bus.proto_err_o} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.obi_req_o, bus.core_ready_o, bus.resp_valid_o, bus.proto_err_o});
    end
    checks++;
    if (bus.outstanding_o !== 2'd0 || bus.obi_addr_o !== 32'h0 || bus.obi_atop_o !== 6'h0) begin
      errors++; $display("FAIL reset_fields: got out=%0d addr=%h atop=%h want 0", bus.outstanding_o, bus.obi_addr_o, bus.obi_atop_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    core_req(32'h1003, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h1000 || bus.core_ready_o !== 1'b1) begin
      errors++; $display("FAIL single_issue: got req=%b addr=%h rdy=%b want 1 00001000 1", bus.obi_req_o, bus.obi_addr_o, bus.core_ready_o);
    end
    step(); idle_in(); @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd1 || bus.obi_req_o !== 1'b0) begin
      errors++; $display("FAIL single_outstanding: got out=%0d req=%b want 1 0", bus.outstanding_o, bus.obi_req_o);
    end
    step();
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 32'hDEADBEEF || bus.resp_we_o !== 1'b0 || bus.resp_err_o !== 1'b0) begin
      errors++; $display("FAIL single_resp: got v=%b d=%h we=%b err=%b want 1 deadbeef 0 0", bus.resp_valid_o, bus.resp_rdata_o, bus.resp_we_o, bus.resp_err_o);
    end
    step(); idle_in(); @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd0) begin
      errors++; $display("FAIL single_drain: got %0d want 0", bus.outstanding_o);
    end
    step();
  endtask

  task automatic test_grant_stall();
    core_req(32'h2000, 1'b1, 32'hA5A5A5A5, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin bus.core_addr_i = 32'h3000; bus.core_wdata_i = 32'h11111111; bus.core_we_i = 1'b0; end
      bus.obi_gnt_i = (c == 3);
      @(negedge clk);
      checks++;
      if (bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h2000 || bus.obi_wdata_o !== 32'hA5A5A5A5 || bus.obi_we_o !== 1'b1 || bus.obi_be_o !== 4'hF) begin
        errors++; $display("FAIL stall_hold c%0d: got req=%b addr=%h wd=%h we=%b be=%h want 1 2000 a5a5a5a5 1 f", c, bus.obi_req_o, bus.obi_addr_o, bus.obi_wdata_o, bus.obi_we_o, bus.obi_be_o);
      end
      checks++;
      if (bus.core_ready_o !== (c == 3)) begin
        errors++; $display("FAIL stall_ready c%0d: got %b want %b", c, bus.core_ready_o, (c == 3));
      end
      step();
    end
    idle_in();
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h12345678;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_we_o !== 1'b1 || bus.resp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL stall_resp: got v=%b we=%b d=%h want 1 1 0", bus.resp_valid_o, bus.resp_we_o, bus.resp_rdata_o);
    end
    step(); idle_in();
  endtask

  task automatic test_pipelining();
    logic [31:0] addrs [3];
    addrs[0] = 32'h100; addrs[1] = 32'h200; addrs[2] = 32'h300;
    for (int i = 0; i < 2; i++) begin
      core_req(addrs[i], 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.core_ready_o !== 1'b1 || bus.obi_addr_o !== addrs[i]) begin
        errors++; $display("FAIL pipe_issue%0d: got rdy=%b addr=%h want 1 %h", i, bus.core_ready_o, bus.obi_addr_o, addrs[i]);
      end
      step();
    end
    core_req(addrs[2], 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd2 || bus.obi_req_o !== 1'b0 || bus.core_ready_o !== 1'b0) begin
      errors++; $display("FAIL pipe_full: got out=%0d req=%b rdy=%b want 2 0 0", bus.outstanding_o, bus.obi_req_o, bus.core_ready_o);
    end
    step();
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hAAAA0001;
    @(negedge clk);
    checks++;
    if (bus.obi_req_o !== 1'b0 || bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 32'hAAAA0001) begin
      errors++; $display("FAIL pipe_rvalid: got req=%b v=%b d=%h want 0 1 aaaa0001", bus.obi_req_o, bus.resp_valid_o, bus.resp_rdata_o);
    end
    step();
    bus.obi_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd1 || bus.obi_req_o !== 1'b1 || bus.obi_addr_o !== 32'h300 || bus.core_ready_o !== 1'b1) begin
      errors++; $display("FAIL pipe_third: got out=%0d req=%b addr=%h rdy=%b want 1 1 300 1", bus.outstanding_o, bus.obi_req_o, bus.obi_addr_o, bus.core_ready_o);
    end
    step();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      bus.obi_rvalid_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.resp_valid_o !== 1'b1) begin
        errors++; $display("FAIL pipe_drain%0d: got %b want 1", i, bus.resp_valid_o);
      end
      step();
    end
    idle_in();
  endtask

  task automatic test_same_cycle();
    core_req(32'h400, 1'b0, 32'h0, 1'b1);
    step();
    core_req(32'h500, 1'b1, 32'h55AA55AA, 1'b1);
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (bus.core_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b1 || bus.resp_we_o !== 1'b0 || bus.resp_rdata_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL same_cycle: got rdy=%b v=%b we=%b d=%h want 1 1 0 cafef00d", bus.core_ready_o, bus.resp_valid_o, bus.resp_we_o, bus.resp_rdata_o);
    end
    step(); idle_in(); @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd1) begin
      errors++; $display("FAIL same_cycle_count: got %0d want 1", bus.outstanding_o);
    end
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'hFFFF;
    #1;
    checks++;
    if (bus.resp_we_o !== 1'b1 || bus.resp_rdata_o !== 32'h0) begin
      errors++; $display("FAIL same_cycle_tag: got we=%b d=%h want 1 0", bus.resp_we_o, bus.resp_rdata_o);
    end
    step(); idle_in();
  endtask

  task automatic test_error();
    core_req(32'h600, 1'b0, 32'h0, 1'b1);
    step(); idle_in();
    bus.obi_rvalid_i = 1'b1; bus.obi_err_i = 1'b1; bus.obi_rdata_i = 32'h55;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_err_o !== 1'b1) begin
      errors++; $display("FAIL err_resp: got v=%b err=%b want 1 1", bus.resp_valid_o, bus.resp_err_o);
    end
    step(); idle_in(); @(negedge clk);
    checks++;
    if (bus.outstanding_o !== 2'd0 || bus.proto_err_o !== 1'b0) begin
      errors++; $display("FAIL err_after: got out=%0d perr=%b want 0 0", bus.outstanding_o, bus.proto_err_o);
    end
    step();
  endtask

  task automatic test_spurious();
    idle_in();
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 32'h77;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL spurious_resp: got %b want 0", bus.resp_valid_o);
    end
    step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.proto_err_o !== 1'b1 || bus.outstanding_o !== 2'd0) begin
        errors++; $display("FAIL spurious_sticky%0d: got perr=%b out=%0d want 1 0", i, bus.proto_err_o, bus.outstanding_o);
      end
      step();
    end
    // Reset in flight: one read outstanding, then a late response is a violation.
    core_req(32'h700, 1'b0, 32'h0, 1'b1);
    step(); idle_in();
    rst_n = 1'b0; #1;
    checks++;
    if (bus.proto_err_o !== 1'b0 || bus.outstanding_o !== 2'd0) begin
      errors++; $display("FAIL async_reset: got perr=%b out=%0d want 0 0", bus.proto_err_o, bus.outstanding_o);
    end
    step(); rst_n = 1'b1; step();
    bus.obi_rvalid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL late_resp: got %b want 0", bus.resp_valid_o);
    end
    step(); idle_in(); @(negedge clk);
    checks++;
    if (bus.proto_err_o !== 1'b1) begin
      errors++; $display("FAIL late_flag: got %b want 1", bus.proto_err_o);
    end
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
  endtask

  task automatic test_random();
    bit          q[$];
    bit          p_valid = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [3:0]  p_be = '0;
    logic        p_we = 1'b0;
    bit          last_acc = 1'b0;
    logic        exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    idle_in();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!bus.core_valid_i || last_acc || $urandom_range(0, 4) == 0) begin
        bus.core_valid_i = ($urandom_range(0, 3) != 0);
        bus.core_addr_i  = $urandom;
        bus.core_we_i    = 1'($urandom_range(0, 1));
        bus.core_be_i    = 4'($urandom);
        bus.core_wdata_i = $urandom;
      end
      bus.obi_gnt_i    = ($urandom_range(0, 2) != 0);
      bus.obi_rvalid_i = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.obi_rdata_i  = $urandom;
      bus.obi_err_i    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      exp_req = p_valid || (bus.core_valid_i && q.size() < MO);
      if (p_valid) begin
        exp_addr = p_addr; exp_we = p_we; exp_be = p_be; exp_wdata = p_wdata;
      end else if (exp_req) begin
        exp_addr = bus.core_addr_i & ~32'h3; exp_we = bus.core_we_i;
        exp_be = bus.core_be_i; exp_wdata = bus.core_wdata_i;
      end else begin
        exp_addr = '0; exp_we = 1'b0; exp_be = '0; exp_wdata = '0;
      end
      checks++;
      if (bus.obi_req_o !== exp_req || bus.core_ready_o !== (exp_req & bus.obi_gnt_i)) begin
        errors++; $display("FAIL rand_req cyc%0d: got req=%b rdy=%b want %b %b", cyc, bus.obi_req_o, bus.core_ready_o, exp_req, exp_req & bus.obi_gnt_i);
      end
      checks++;
      if (bus.obi_addr_o !== exp_addr || bus.obi_we_o !== exp_we || bus.obi_be_o !== exp_be || bus.obi_wdata_o !== exp_wdata) begin
        errors++; $display("FAIL rand_fields cyc%0d: got %h %b %h %h want %h %b %h %h", cyc, bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o, bus.obi_wdata_o, exp_addr, exp_we, exp_be, exp_wdata);
      end
      checks++;
      if (bus.outstanding_o !== 2'(q.size()) || bus.proto_err_o !== 1'b0 || bus.resp_valid_o !== bus.obi_rvalid_i) begin
        errors++; $display("FAIL rand_state cyc%0d: got out=%0d perr=%b v=%b want %0d 0 %b", cyc, bus.outstanding_o, bus.proto_err_o, bus.resp_valid_o, q.size(), bus.obi_rvalid_i);
      end
      if (bus.obi_rvalid_i) begin
        checks++;
        if (bus.resp_we_o !== q[0] || bus.resp_err_o !== bus.obi_err_i || bus.resp_rdata_o !== (q[0] ? 32'h0 : bus.obi_rdata_i)) begin
          errors++; $display("FAIL rand_resp cyc%0d: got we=%b err=%b d=%h want %b %b %h", cyc, bus.resp_we_o, bus.resp_err_o, bus.resp_rdata_o, q[0], bus.obi_err_i, q[0] ? 32'h0 : bus.obi_rdata_i);
        end
        void'(q.pop_front());
      end
      last_acc = exp_req && bus.obi_gnt_i;
      if (last_acc) q.push_back(exp_we);
      if (!p_valid && exp_req && !bus.obi_gnt_i) begin
        p_valid = 1'b1; p_addr = exp_addr; p_we = exp_we; p_be = exp_be; p_wdata = exp_wdata;
      end else if (p_valid && bus.obi_gnt_i) begin
        p_valid = 1'b0;
      end
      step();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single_read();
    test_grant_stall();
    test_pipelining();
    test_same_cycle();
    test_error();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
